data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache_pkg.sv | 37 +++
 rtl/data_cache_array.sv | 53 +++++
 rtl/data_cache.sv | 194 +++++++++++++++++++
 tb/tb_data_cache.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_cache_pkg.sv
// rtl/data_cache_pkg.sv - shared constants, FSM encoding and helpers for data_cache
package data_cache_pkg;

  localparam int ADDR_WIDTH  = 16;
  localparam int WORD_SIZE   = 16;
  localparam int LINE_WORDS  = 4;
  localparam int LINE_SIZE   = WORD_SIZE * LINE_WORDS;
  localparam int OFFSET_BITS = 2;
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    FILL_REQ,
    FILL_WAIT,
    WB_REQ,
    WB_WAIT,
    RESP
  } state_e;

  // Replace one word of a line, leaving the other words untouched.
  function automatic logic [LINE_SIZE-1:0] merge_word(
    input logic [LINE_SIZE-1:0]   line,
    input logic [OFFSET_BITS-1:0] offset,
    input logic [WORD_SIZE-1:0]   word
  );
    logic [LINE_SIZE-1:0] result;
    result = line;
    result[offset*WORD_SIZE +: WORD_SIZE] = word;
    return result;
  endfunction

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == COUNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/data_cache_array.sv
// rtl/data_cache_array.sv - valid/tag/data storage, one line write port, combinational read
module data_cache_array #(
  parameter int NUM_LINES = 4,
  parameter int INDEX_W   = 2,
  parameter int TAG_W     = 12,
  parameter int LINE_BITS = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [INDEX_W-1:0]   rd_index,
  output logic                 rd_valid,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [LINE_BITS-1:0] rd_line,
  input  logic                 wr_en,
  input  logic [INDEX_W-1:0]   wr_index,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [LINE_BITS-1:0] wr_line
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];
  logic [LINE_BITS-1:0] data_d [NUM_LINES];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

  // A line write installs the whole line and marks it valid with its new tag.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d[wr_index] = 1'b1;
      tag_d[wr_index]   = wr_tag;
      data_d[wr_index]  = wr_line;
    end
  end

  // Only the valid bits are reset; stale tags and data are harmless once invalid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-allocate write-through data cache
module data_cache #(
  parameter int NUM_LINES  = 4,
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            cpu_read,
  input  logic                            cpu_write,
  input  logic [15:0]                     cpu_address,
  input  logic [WORD_SIZE-1:0]            cpu_wdata,
  output logic [WORD_SIZE-1:0]            cpu_rdata,
  output logic                            cpu_done,
  output logic                            mem_readM,
  output logic                            mem_writeM,
  output logic [15:0]                     mem_address,
  output logic [WORD_SIZE*LINE_WORDS-1:0] mem_wdata,
  input  logic [WORD_SIZE*LINE_WORDS-1:0] mem_rdata,
  input  logic                            mem_readyM,
  input  logic                            mem_input_readyM,
  input  logic                            mem_doneM,
  output logic [15:0]                     hit_count,
  output logic [15:0]                     miss_count
);

  import data_cache_pkg::*;

  localparam int LINE_BITS = WORD_SIZE * LINE_WORDS;
  localparam int INDEX_W   = $clog2(NUM_LINES);
  localparam int TAG_W     = ADDR_WIDTH - OFFSET_BITS - INDEX_W;

  logic [OFFSET_BITS-1:0] addr_offset;
  logic [INDEX_W-1:0]     addr_index;
  logic [TAG_W-1:0]       addr_tag;

  assign addr_offset = cpu_address[OFFSET_BITS-1:0];
  assign addr_index  = cpu_address[OFFSET_BITS +: INDEX_W];
  assign addr_tag    = cpu_address[ADDR_WIDTH-1 -: TAG_W];

  logic                 rd_valid;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_line;
  logic                 wr_en;
  logic [LINE_BITS-1:0] wr_line;
  logic                 hit;

  data_cache_array #(
    .NUM_LINES (NUM_LINES),
    .INDEX_W   (INDEX_W),
    .TAG_W     (TAG_W),
    .LINE_BITS (LINE_BITS)
  ) u_array (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_index (addr_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (wr_en),
    .wr_index (addr_index),
    .wr_tag   (addr_tag),
    .wr_line  (wr_line)
  );

  assign hit       = rd_valid && (rd_tag == addr_tag);
  assign cpu_rdata = rd_line[addr_offset*WORD_SIZE +: WORD_SIZE];

  state_e               state_q, state_d;
  logic                 op_write_q, op_write_d;
  logic                 cpu_done_q, cpu_done_d;
  logic                 mem_readM_q, mem_readM_d;
  logic                 mem_writeM_q, mem_writeM_d;
  logic [15:0]          mem_address_q, mem_address_d;
  logic [LINE_BITS-1:0] mem_wdata_q, mem_wdata_d;
  logic [15:0]          hit_count_q, hit_count_d;
  logic [15:0]          miss_count_q, miss_count_d;

  assign cpu_done    = cpu_done_q;
  assign mem_readM   = mem_readM_q;
  assign mem_writeM  = mem_writeM_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;

  // Next-state logic; memory request pulses are raised by the edge that enters or
  // holds a *_REQ state, so each pulse occupies exactly one cycle of that state.
  always_comb begin
    state_d       = state_q;
    op_write_d    = op_write_q;
    cpu_done_d    = 1'b0;
    mem_readM_d   = 1'b0;
    mem_writeM_d  = 1'b0;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
    wr_en         = 1'b0;
    wr_line       = rd_line;
    case (state_q)
      IDLE: begin
        if (cpu_write || cpu_read) begin
          op_write_d    = cpu_write;
          mem_address_d = {cpu_address[15:2], 2'b00};
          if (hit) begin
            hit_count_d = sat_inc(hit_count_q);
            if (cpu_write) begin
              wr_en        = 1'b1;
              wr_line      = merge_word(rd_line, addr_offset, cpu_wdata);
              mem_wdata_d  = wr_line;
              mem_writeM_d = mem_readyM;
              state_d      = WB_REQ;
            end else begin
              cpu_done_d = 1'b1;
              state_d    = RESP;
            end
          end else begin
            miss_count_d = sat_inc(miss_count_q);
            mem_readM_d  = mem_readyM;
            state_d      = FILL_REQ;
          end
        end
      end
      FILL_REQ: begin
        if (mem_readM_q) begin
          state_d = FILL_WAIT;
        end else begin
          mem_readM_d = mem_readyM;
        end
      end
      FILL_WAIT: begin
        if (mem_input_readyM) begin
          wr_en = 1'b1;
          if (op_write_q) begin
            wr_line      = merge_word(mem_rdata, addr_offset, cpu_wdata);
            mem_wdata_d  = wr_line;
            mem_writeM_d = mem_readyM;
            state_d      = WB_REQ;
          end else begin
            wr_line    = mem_rdata;
            cpu_done_d = 1'b1;
            state_d    = RESP;
          end
        end
      end
      WB_REQ: begin
        if (mem_writeM_q) begin
          state_d = WB_WAIT;
        end else begin
          mem_writeM_d = mem_readyM;
        end
      end
      WB_WAIT: begin
        if (mem_doneM) begin
          cpu_done_d = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any memory transaction in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      op_write_q    <= 1'b0;
      cpu_done_q    <= 1'b0;
      mem_readM_q   <= 1'b0;
      mem_writeM_q  <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      hit_count_q   <= '0;
      miss_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      op_write_q    <= op_write_d;
      cpu_done_q    <= cpu_done_d;
      mem_readM_q   <= mem_readM_d;
      mem_writeM_q  <= mem_writeM_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      hit_count_q   <= hit_count_d;
      miss_count_q  <= miss_count_d;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - directed scoreboard bench for data_cache
module tb_data_cache;

  logic        clk;
  logic        reset_n;
  logic        cpu_read;
  logic        cpu_write;
  logic [15:0] cpu_address;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_done;
  logic        mem_readM;
  logic        mem_writeM;
  logic [15:0] mem_address;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_readyM;
  logic        mem_input_readyM;
  logic        mem_doneM;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  data_cache dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cpu_read         (cpu_read),
    .cpu_write        (cpu_write),
    .cpu_address      (cpu_address),
    .cpu_wdata        (cpu_wdata),
    .cpu_rdata        (cpu_rdata),
    .cpu_done         (cpu_done),
    .mem_readM        (mem_readM),
    .mem_writeM       (mem_writeM),
    .mem_address      (mem_address),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_readyM       (mem_readyM),
    .mem_input_readyM (mem_input_readyM),
    .mem_doneM        (mem_doneM),
    .hit_count        (hit_count),
    .miss_count       (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mem     [256];
  logic [15:0] ref_mem [256];
  logic [15:0] exp_q   [$];

  // Backing memory: accepts a request seen at a falling edge, answers six falling
  // edges later with a one-cycle input-ready/done pulse.
  bit          busy = 1'b0;
  bit          hold = 1'b0;
  bit          op_rd = 1'b0;
  int          cnt = 0;
  logic [7:0]  ra = '0;
  int          rd_pulses = 0;
  int          wr_pulses = 0;
  int          viol = 0;
  int          done_cnt = 0;
  bit          prev_rd = 1'b0;
  bit          prev_wr = 1'b0;
  logic [15:0] last_raddr = '0;
  logic [15:0] last_waddr = '0;
  logic [63:0] last_wdata = '0;

  assign mem_readyM = !busy && !hold;

  initial begin
    mem_input_readyM = 1'b0;
    mem_doneM        = 1'b0;
    mem_rdata        = '0;
  end

  always @(negedge clk) begin
    if (cpu_done) done_cnt++;
    if (mem_readM && mem_writeM) viol++;
    if ((mem_readM && prev_rd) || (mem_writeM && prev_wr)) viol++;
    if ((mem_readM || mem_writeM) && !mem_readyM) viol++;
    prev_rd = mem_readM;
    prev_wr = mem_writeM;
    if (mem_readM) begin
      rd_pulses++;
      last_raddr = mem_address;
    end
    if (mem_writeM) begin
      wr_pulses++;
      last_waddr = mem_address;
      last_wdata = mem_wdata;
    end
    if (mem_input_readyM || mem_doneM) begin
      mem_input_readyM = 1'b0;
      mem_doneM        = 1'b0;
      busy             = 1'b0;
    end else if (busy) begin
      cnt--;
      if (cnt == 0) begin
        if (op_rd) begin
          mem_rdata        = {mem[ra+3], mem[ra+2], mem[ra+1], mem[ra]};
          mem_input_readyM = 1'b1;
        end
        mem_doneM = 1'b1;
      end
    end else if (mem_readM && !hold) begin
      busy  = 1'b1;
      op_rd = 1'b1;
      cnt   = 6;
      ra    = mem_address[7:0];
    end else if (mem_writeM && !hold) begin
      busy  = 1'b1;
      op_rd = 1'b0;
      cnt   = 6;
      ra    = mem_address[7:0];
      for (int k = 0; k < 4; k++) mem[ra+k[7:0]] = mem_wdata[16*k +: 16];
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One CPU request: expected read data goes on the scoreboard at issue and is
  // popped when cpu_done appears. Optionally keeps the memory busy for hold_n cycles.
  task automatic cpu_access(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                            input int exp_lat, input int hold_n, input string tag);
    int lat;
    int rd_before;
    logic [15:0] exp;
    rd_before = rd_pulses;
    if (wr) ref_mem[addr[7:0]] = wdata;
    else exp_q.push_back(ref_mem[addr[7:0]]);
    if (hold_n > 0) hold = 1'b1;
    cpu_address = addr;
    cpu_wdata   = wdata;
    cpu_write   = wr;
    cpu_read    = !wr;
    lat = 0;
    do begin
      tick();
      lat++;
      if (hold_n > 0 && lat == hold_n + 1) begin
        check({tag, " no mem_readM while not ready"}, 64'(rd_pulses), 64'(rd_before));
        hold = 1'b0;
      end
    end while (!cpu_done && lat < 60);
    check({tag, " cpu_done"}, 64'(cpu_done), 64'd1);
    if (!wr) begin
      exp = exp_q.pop_front();
      check({tag, " rdata"}, 64'(cpu_rdata), 64'(exp));
    end
    if (exp_lat > 0) check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    tick();
  endtask

  initial begin
    logic [63:0] exp_line;
    int done_before;
    int rd_before;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0] = 16'h9023;
    mem[1] = 16'h0001;
    mem[2] = 16'hFFFF;
    mem[3] = 16'h0000;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

    reset_n     = 1'b0;
    cpu_read    = 1'b0;
    cpu_write   = 1'b0;
    cpu_address = '0;
    cpu_wdata   = '0;
    repeat (3) tick();
    check("reset cpu_done", 64'(cpu_done), 64'd0);
    check("reset mem_readM", 64'(mem_readM), 64'd0);
    check("reset mem_writeM", 64'(mem_writeM), 64'd0);
    check("reset mem_address", 64'(mem_address), 64'd0);
    check("reset mem_wdata", mem_wdata, 64'd0);
    check("reset hit_count", 64'(hit_count), 64'd0);
    check("reset miss_count", 64'(miss_count), 64'd0);
    reset_n = 1'b1;
    tick();

    cpu_access(1'b0, 16'h0001, 16'h0000, 8, 0, "cold read 0x0001");
    check("cold read mem_readM pulses", 64'(rd_pulses), 64'd1);
    check("cold read mem_address", 64'(last_raddr), 64'h0000);
    check("cold read miss_count", 64'(miss_count), 64'd1);
    check("cold read hit_count", 64'(hit_count), 64'd0);

    cpu_access(1'b0, 16'h0002, 16'h0000, 1, 0, "hit read 0x0002");
    check("hit read no mem request", 64'(rd_pulses), 64'd1);
    check("hit read hit_count", 64'(hit_count), 64'd1);

    cpu_access(1'b1, 16'h0001, 16'h1234, 8, 0, "write hit 0x0001");
    check("write hit mem_writeM pulses", 64'(wr_pulses), 64'd1);
    check("write hit mem_address", 64'(last_waddr), 64'h0000);
    check("write hit mem_wdata", last_wdata, 64'h0000_FFFF_1234_9023);
    check("write hit hit_count", 64'(hit_count), 64'd2);
    cpu_access(1'b0, 16'h0001, 16'h0000, 1, 0, "re-read 0x0001");

    cpu_access(1'b0, 16'h0005, 16'h0000, 8, 0, "read 0x0005");
    check("read 0x0005 miss_count", 64'(miss_count), 64'd2);

    cpu_access(1'b1, 16'h0045, 16'hBEEF, 16, 0, "write miss 0x0045");
    exp_line = {ref_mem[8'h47], ref_mem[8'h46], ref_mem[8'h45], ref_mem[8'h44]};
    check("write miss fill pulses", 64'(rd_pulses), 64'd3);
    check("write miss fill address", 64'(last_raddr), 64'h0044);
    check("write miss wb address", 64'(last_waddr), 64'h0044);
    check("write miss wb data", last_wdata, exp_line);
    check("write miss memory word 0x45", 64'(mem[8'h45]), 64'h0000_0000_0000_BEEF);
    check("write miss miss_count", 64'(miss_count), 64'd3);
    cpu_access(1'b0, 16'h0045, 16'h0000, 1, 0, "read back 0x0045");
    check("read back hit_count", 64'(hit_count), 64'd4);
    cpu_access(1'b0, 16'h0005, 16'h0000, 8, 0, "evicted read 0x0005");
    check("evicted read miss_count", 64'(miss_count), 64'd4);

    cpu_access(1'b0, 16'h0009, 16'h0000, 12, 3, "held-ready read 0x0009");
    check("held-ready single pulse", 64'(rd_pulses), 64'd5);

    rd_before   = rd_pulses;
    cpu_address = 16'h000D;
    cpu_read    = 1'b1;
    repeat (3) tick();
    done_before = done_cnt;
    reset_n  = 1'b0;
    cpu_read = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (10) tick();
    check("mid-fill reset issued one fill", 64'(rd_pulses), 64'(rd_before + 1));
    check("mid-fill reset no cpu_done", 64'(done_cnt), 64'(done_before));
    check("mid-fill reset hit_count", 64'(hit_count), 64'd0);
    check("mid-fill reset miss_count", 64'(miss_count), 64'd0);
    cpu_access(1'b0, 16'h0001, 16'h0000, 8, 0, "post-reset read 0x0001");
    check("post-reset miss_count", 64'(miss_count), 64'd1);
    check("post-reset hit_count", 64'(hit_count), 64'd0);

    check("memory handshake violations", 64'(viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
